nois_system_nios2_qsys_0_oci_dct_unpacker: RTL and testbench

- Reader end of the OCI instruction-trace direct-count (DCT) buffer.
- Accepts a packed word of up to 15 two-bit trace codes (dct_buffer plus dct_count) over a valid/ready handshake.
- Serialises the codes oldest-first onto a 2-bit valid/ready stream for the trace capture/checker.
- Tracks test termination, reporting drain and abort status and event counters.

---
 rtl/nois_system_nios2_qsys_0_oci_dct_unpacker.sv | 143 ++++++++++++++
 tb/tb_nois_system_nios2_qsys_0_oci_dct_unpacker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nois_system_nios2_qsys_0_oci_dct_unpacker.sv
// Reader end of the OCI trace DCT buffer: unpacks up to 15 two-bit codes per
// word onto a valid/ready stream, oldest first, and tracks test termination.
module nois_system_nios2_qsys_0_oci_dct_unpacker #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [29:0]      dct_buffer,
    input  logic [3:0]       dct_count,
    input  logic             test_ending,
    input  logic             test_has_ended,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic             out_last,
    output logic             drained,
    output logic             aborted,
    output logic [CNT_W-1:0] words_accepted,
    output logic [CNT_W-1:0] codes_emitted,
    output logic [CNT_W-1:0] empty_words
);

    localparam int unsigned BUF_W  = 30;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned DCNT_W = 4;
    localparam int unsigned SH_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNPACK = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [BUF_W-1:0]    shreg, shreg_nxt;
    logic [DCNT_W-1:0]   remaining, rem_nxt;
    logic                end_req, end_req_nxt;
    logic [CNT_W-1:0]    wa_nxt, ce_nxt, ew_nxt;
    logic                drained_nxt, aborted_nxt;
    logic                out_valid_nxt, out_last_nxt, in_ready_nxt;
    logic [CODE_W-1:0]   out_code_nxt;
    logic [SH_W-1:0]     shamt;
    logic                accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            shreg          <= '0;
            remaining      <= '0;
            end_req        <= 1'b0;
            words_accepted <= '0;
            codes_emitted  <= '0;
            empty_words    <= '0;
            drained        <= 1'b0;
            aborted        <= 1'b0;
            out_valid      <= 1'b0;
            out_code       <= '0;
            out_last       <= 1'b0;
            in_ready       <= 1'b0;
        end else begin
            state          <= state_nxt;
            shreg          <= shreg_nxt;
            remaining      <= rem_nxt;
            end_req        <= end_req_nxt;
            words_accepted <= wa_nxt;
            codes_emitted  <= ce_nxt;
            empty_words    <= ew_nxt;
            drained        <= drained_nxt;
            aborted        <= aborted_nxt;
            out_valid      <= out_valid_nxt;
            out_code       <= out_code_nxt;
            out_last       <= out_last_nxt;
            in_ready       <= in_ready_nxt;
        end
    end

    // Next state; outputs are precomputed from the next state so they stay registered
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        rem_nxt     = remaining;
        end_req_nxt = end_req | test_ending;
        wa_nxt      = words_accepted;
        ce_nxt      = codes_emitted;
        ew_nxt      = empty_words;
        aborted_nxt = aborted;
        shamt       = SH_W'(BUF_W) - {dct_count, 1'b0};
        accept      = (state == ST_IDLE) && in_ready && in_valid;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    wa_nxt = sat_inc(words_accepted);
                    if (dct_count == '0) begin
                        ew_nxt = sat_inc(empty_words);
                    end else begin
                        shreg_nxt = dct_buffer >> shamt;
                        rem_nxt   = dct_count;
                        state_nxt = ST_UNPACK;
                    end
                end else if (end_req) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_UNPACK: begin
                if (out_ready) begin
                    shreg_nxt = shreg >> CODE_W;
                    rem_nxt   = remaining - DCNT_W'(1);
                    ce_nxt    = sat_inc(codes_emitted);
                    if (remaining == DCNT_W'(1)) begin
                        state_nxt = (end_req | test_ending) ? ST_DONE : ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

        // Abort discards pending codes and suppresses this edge's handshakes
        if (test_has_ended) begin
            state_nxt   = ST_DONE;
            shreg_nxt   = shreg;
            rem_nxt     = remaining;
            wa_nxt      = words_accepted;
            ce_nxt      = codes_emitted;
            ew_nxt      = empty_words;
            aborted_nxt = aborted | (state == ST_UNPACK);
        end

        out_valid_nxt = (state_nxt == ST_UNPACK);
        out_code_nxt  = out_valid_nxt ? shreg_nxt[CODE_W-1:0] : '0;
        out_last_nxt  = out_valid_nxt && (rem_nxt == DCNT_W'(1));
        in_ready_nxt  = (state_nxt == ST_IDLE) && !end_req_nxt;
        drained_nxt   = drained | (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_nois_system_nios2_qsys_0_oci_dct_unpacker.sv
// Randomised and directed bench for the DCT unpacker against a queue-based
// model of the code stream, handshake availability and statistics.
module tb_nois_system_nios2_qsys_0_oci_dct_unpacker;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_code;
    logic        out_last;
    logic        drained;
    logic        aborted;
    logic [15:0] words_accepted;
    logic [15:0] codes_emitted;
    logic [15:0] empty_words;

    nois_system_nios2_qsys_0_oci_dct_unpacker #(.CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_code       (out_code),
        .out_last       (out_last),
        .drained        (drained),
        .aborted        (aborted),
        .words_accepted (words_accepted),
        .codes_emitted  (codes_emitted),
        .empty_words    (empty_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pending codes as {last, code}, oldest at the front
    logic [2:0] q[$];
    bit m_end_req, m_done, m_aborted, m_started;
    int m_wa, m_ce, m_ew;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        q.delete();
        m_end_req = 0; m_done = 0; m_aborted = 0; m_started = 0;
        m_wa = 0; m_ce = 0; m_ew = 0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_words"}, 32'(words_accepted), 32'(m_wa));
        check({tag, "_codes"}, 32'(codes_emitted), 32'(m_ce));
        check({tag, "_empty"}, 32'(empty_words), 32'(m_ew));
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(input bit iv, input logic [29:0] b, input logic [3:0] c,
                        input bit ordy, input bit tend, input bit thend);
        bit exp_vld, exp_rdy, end_old, was_empty;
        int cc;
        in_valid = iv; dct_buffer = b; dct_count = c;
        out_ready = ordy; test_ending = tend; test_has_ended = thend;
        exp_vld = !m_done && q.size() > 0;
        exp_rdy = m_started && q.size() == 0 && !m_end_req && !m_done;
        check("out_valid", 32'(out_valid), 32'(exp_vld));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("drained", 32'(drained), 32'(m_done));
        check("aborted", 32'(aborted), 32'(m_aborted));
        if (exp_vld) begin
            check("out_code", 32'(out_code), 32'(q[0][1:0]));
            check("out_last", 32'(out_last), 32'(q[0][2]));
        end
        end_old = m_end_req;
        was_empty = (q.size() == 0);
        if (thend) begin
            if (!m_done && !was_empty) m_aborted = 1;
            m_done = 1;
            q.delete();
        end else if (!m_done) begin
            if (exp_vld && ordy) begin
                void'(q.pop_front());
                m_ce++;
                if (q.size() == 0 && (end_old || tend)) m_done = 1;
            end
            if (iv && exp_rdy) begin
                cc = int'(c);
                m_wa++;
                if (cc == 0) m_ew++;
                for (int i = 0; i < cc; i++)
                    q.push_back({(i == cc - 1), b[(30 - 2 * cc) + 2 * i +: 2]});
            end else if (was_empty && end_old) begin
                m_done = 1;
            end
        end
        if (tend) m_end_req = 1;
        m_started = 1;
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(0, 30'h0, 4'd0, ordy, 0, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() > 0; n++) idle(1);
        idle(1);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 0; dct_buffer = '0; dct_count = '0;
        out_ready = 0; test_ending = 0; test_has_ended = 0;
        #1 reset_n = 1'b0;
        #1;
        check({tag, "_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_code"}, 32'(out_code), 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd0);
        check({tag, "_drained"}, 32'(drained), 32'd0);
        check({tag, "_aborted"}, 32'(aborted), 32'd0);
        check({tag, "_stats"}, 32'({words_accepted, codes_emitted} | 32'(empty_words)), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [29:0] full_buf;
    int run;

    initial begin
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
        do_reset("rst0");

        // Four-code word with out_ready held high
        idle(1);
        step(1, 30'h3C000000, 4'd4, 1, 0, 0);
        drain();
        check("t1_words", 32'(words_accepted), 32'd1);
        check("t1_codes", 32'(codes_emitted), 32'd4);
        check_stats("t1");

        // Full 15-code word: 15 consecutive valid cycles then a bubble
        for (int i = 0; i < 15; i++) full_buf[2*i +: 2] = 2'(i % 4);
        step(1, full_buf, 4'd15, 1, 0, 0);
        run = 0;
        while (out_valid && run < 20) begin
            run++;
            idle(1);
        end
        check("t2_run", 32'(run), 32'd15);
        idle(1);
        check_stats("t2");

        // Three empty words back to back
        for (int i = 0; i < 3; i++) step(1, 30'h2AAAAAAA, 4'd0, 1, 0, 0);
        idle(1);
        check("t3_empty", 32'(empty_words), 32'd3);
        check_stats("t3");

        // Backpressure during a three-code word
        step(1, 30'h1B000000, 4'd3, 0, 0, 0);
        step(0, 30'h0, 4'd0, 1, 0, 0);
        step(0, 30'h0, 4'd0, 0, 0, 0);
        step(0, 30'h0, 4'd0, 0, 0, 0);
        step(0, 30'h0, 4'd0, 1, 0, 0);
        step(0, 30'h0, 4'd0, 1, 0, 0);
        idle(1);
        check("t4_codes", 32'(codes_emitted), 32'd22);
        check_stats("t4");

        // Graceful end requested mid-word
        step(1, 30'h3FEDCBA9, 4'd5, 1, 0, 0);
        step(0, 30'h0, 4'd0, 1, 1, 0);
        drain();
        for (int i = 0; i < 3; i++) step(1, 30'h12345678, 4'd2, 1, 0, 0);
        check("t5_drained", 32'(drained), 32'd1);
        check("t5_aborted", 32'(aborted), 32'd0);
        check_stats("t5");
        do_reset("rst1");

        // Abort after two of six codes, then reset mid-word
        idle(1);
        step(1, 30'h2D3C4B5A, 4'd6, 1, 0, 0);
        idle(1);
        idle(1);
        step(1, 30'h11111111, 4'd3, 1, 0, 1);
        idle(1);
        check("t6_codes", 32'(codes_emitted), 32'd2);
        check("t6_aborted", 32'(aborted), 32'd1);
        check_stats("t6");
        do_reset("rst2");
        idle(1);
        step(1, 30'h0F0F0F0F, 4'd7, 1, 0, 0);
        idle(0);
        do_reset("rst3");

        // Random traffic
        idle(1);
        for (int n = 0; n < 600; n++)
            step(bit'($urandom_range(0, 1)), 30'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom % 4) != 0, 0, 0);
        drain();
        check_stats("rnd");

        // Random traffic ending in a random termination
        for (int n = 0; n < 200; n++)
            step(bit'($urandom_range(0, 1)), 30'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom % 3) != 0, ($urandom % 97) == 0, ($urandom % 151) == 0);
        step(0, 30'h0, 4'd0, 1, 0, 1);
        idle(1);
        check_stats("rnd_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
